// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Hazard scoreboard for an in-order F/D/E/M/W pipeline. It tracks the
//   destination registers of the instructions that sit between E and W,
//   picks forwarding sources for the two decode operands, detects load-use
//   hazards, and produces the stall/bubble controls for the pipeline
//   registers. An optional multi-cycle execute counter holds E while a long
//   operation completes.
//
//   Build option:
//     SCB_MC_EN  defined   -> multi-cycle latency counter present
//                undefined -> counter omitted, busy/regE_stall/regM_bubble tied 0
//
//   Ports:
//     clk, rst                     clock (rising edge), async active-low reset
//     dec_i_*                      decode-stage instruction description
//     execute_i_need_jump          taken redirect resolved in E
//     ctrl_o_regF/regD_stall       hold fetch/decode registers
//     ctrl_o_regD/regE_bubble      insert NOP into D/E
//     ctrl_o_regE_stall            hold E during a multi-cycle op
//     ctrl_o_regM_bubble           NOP into M during a multi-cycle op
//     sb_o_issue                   decode instruction enters E this edge
//     sb_o_fwd1_sel, sb_o_fwd2_sel 0 = regfile, k = in-flight entry k-1
//     sb_o_busy                    multi-cycle counter nonzero
module pipe_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int WB_DEPTH = 3,
    parameter int LAT_W    = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dec_i_valid,
    input  logic [REG_AW-1:0]                 dec_i_rs1,
    input  logic [REG_AW-1:0]                 dec_i_rs2,
    input  logic                              dec_i_rs1_used,
    input  logic                              dec_i_rs2_used,
    input  logic [REG_AW-1:0]                 dec_i_rd,
    input  logic                              dec_i_wen,
    input  logic                              dec_i_is_load,
    input  logic [LAT_W-1:0]                  dec_i_mc_lat,
    input  logic                              execute_i_need_jump,
    output logic                              ctrl_o_regF_stall,
    output logic                              ctrl_o_regD_stall,
    output logic                              ctrl_o_regD_bubble,
    output logic                              ctrl_o_regE_bubble,
    output logic                              ctrl_o_regE_stall,
    output logic                              ctrl_o_regM_bubble,
    output logic                              sb_o_issue,
    output logic [$clog2(WB_DEPTH+1)-1:0]     sb_o_fwd1_sel,
    output logic [$clog2(WB_DEPTH+1)-1:0]     sb_o_fwd2_sel,
    output logic                              sb_o_busy
);

    localparam int SEL_W = $clog2(WB_DEPTH+1);

    logic [WB_DEPTH-1:0] entValid;
    logic [WB_DEPTH-1:0] entLoad;
    logic [REG_AW-1:0]   entRd [WB_DEPTH];

    logic [SEL_W-1:0] fwd1Sel;
    logic [SEL_W-1:0] fwd2Sel;
    logic             busy;
    logic             loadUse;
    logic             jumpEff;
    logic             stall;
    logic             issue;

    // The oldest entry's load flag is only carried so the entry is complete;
    // nothing downstream of W needs it.
    logic unusedOldLoad;
    assign unusedOldLoad = entLoad[WB_DEPTH-1];

    // Forwarding select for each operand. Walking from the oldest entry to
    // the youngest lets the youngest matching producer overwrite older ones,
    // so the most recent value of the register wins. Register 0 never
    // forwards since it is hardwired.
    always_comb begin
        fwd1Sel = '0;
        fwd2Sel = '0;
        for (int i = WB_DEPTH-1; i >= 0; i--) begin
            if (dec_i_rs1_used && dec_i_rs1 != '0 && entValid[i] && entRd[i] == dec_i_rs1)
                fwd1Sel = SEL_W'(i+1);
            if (dec_i_rs2_used && dec_i_rs2 != '0 && entValid[i] && entRd[i] == dec_i_rs2)
                fwd2Sel = SEL_W'(i+1);
        end
    end

    // A load sitting in E has no result yet, so a consumer in decode that
    // needs it has to wait one cycle. While a multi-cycle op holds E the jump
    // input is not trustworthy, so it only counts when the counter is idle.
    assign loadUse = entLoad[0] && (fwd1Sel == SEL_W'(1) || fwd2Sel == SEL_W'(1));
    assign jumpEff = execute_i_need_jump && !busy;
    assign stall   = (loadUse || busy) && !jumpEff;
    assign issue   = dec_i_valid && !stall && !jumpEff && !loadUse;

    // In-flight tracking: every free-running edge advances the pipeline by
    // one stage and records what (if anything) entered E. A multi-cycle op
    // freezes the whole picture because nothing behind E can move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entValid <= '0;
            entLoad  <= '0;
            for (int i = 0; i < WB_DEPTH; i++)
                entRd[i] <= '0;
        end else if (!busy) begin
            for (int i = WB_DEPTH-1; i > 0; i--) begin
                entValid[i] <= entValid[i-1];
                entLoad[i]  <= entLoad[i-1];
                entRd[i]    <= entRd[i-1];
            end
            entValid[0] <= issue && dec_i_wen && dec_i_rd != '0;
            entLoad[0]  <= issue && dec_i_is_load;
            entRd[0]    <= dec_i_rd;
        end
    end

`ifdef SCB_MC_EN
    logic [LAT_W-1:0] mcCnt;

    // Multi-cycle latency counter: loaded by an issuing long op, then counts
    // down to zero. Issue is blocked while busy, so load and decrement never
    // compete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mcCnt <= '0;
        else if (issue && dec_i_mc_lat != '0)
            mcCnt <= dec_i_mc_lat;
        else if (mcCnt != '0)
            mcCnt <= mcCnt - LAT_W'(1);
    end

    assign busy = (mcCnt != '0);
`else
    logic unusedMcLat;
    assign unusedMcLat = ^dec_i_mc_lat;
    assign busy = 1'b0;
`endif

    // All controls are forced quiet while reset is held so the pipeline
    // registers see no stray stall/bubble during reset.
    assign ctrl_o_regF_stall  = rst && stall;
    assign ctrl_o_regD_stall  = rst && stall;
    assign ctrl_o_regD_bubble = rst && jumpEff;
    assign ctrl_o_regE_bubble = rst && (jumpEff || (loadUse && !busy));
    assign ctrl_o_regE_stall  = rst && busy;
    assign ctrl_o_regM_bubble = rst && busy;
    assign sb_o_issue         = rst && issue;
    assign sb_o_busy          = rst && busy;
    assign sb_o_fwd1_sel      = rst ? fwd1Sel : '0;
    assign sb_o_fwd2_sel      = rst ? fwd2Sel : '0;

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-index width (2^REG_AW architectural registers).
REQ-002 SHALL have parameter WB_DEPTH, default 3, meaning in-flight stages tracked from E up to and including W (entry 0 = E).
REQ-003 SHALL have parameter LAT_W, default 5, meaning width of the multi-cycle latency field.
REQ-004 SHALL have ports, in this order (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dec_i_valid  in  1  decode holds a valid instruction.
- dec_i_rs1, dec_i_rs2  in  REG_AW  source indices.
- dec_i_rs1_used, dec_i_rs2_used  in  1  source actually read.
- dec_i_rd  in  REG_AW  destination index.
- dec_i_wen  in  1  instruction writes rd.
- dec_i_is_load  in  1  result is available only after M.
- dec_i_mc_lat  in  LAT_W  extra E cycles (0 = single-cycle op).
- execute_i_need_jump  in  1  taken redirect resolved in E.
- ctrl_o_regF_stall, ctrl_o_regD_stall  out  1  hold F/D.
- ctrl_o_regD_bubble, ctrl_o_regE_bubble  out  1  insert NOP.
- ctrl_o_regE_stall, ctrl_o_regM_bubble  out  1  hold E / NOP into M during multi-cycle op.
- sb_o_issue  out  1  decode instruction enters E this edge.
- sb_o_fwd1_sel, sb_o_fwd2_sel  out  clog2(WB_DEPTH+1)  0 = regfile, k = entry k-1.
- sb_o_busy  out  1  multi-cycle counter nonzero.

Function
REQ-005 SHALL keep WB_DEPTH entries {valid, rd, is_load}; entry i = instruction i+1 stages past D.
REQ-006 SHALL, on each edge with sb_o_busy = 0, shift entries i -> i+1 (oldest dropped) and load entry 0 with {dec_i_wen && rd != 0, rd, is_load} if sb_o_issue, else invalid.
REQ-007 SHALL freeze all entries while sb_o_busy = 1.
REQ-008 SHALL define hit(rs) = rs_used && rs != 0 && some valid entry has rd == rs; fwd_sel SHALL select the youngest (lowest-index) hit, combinationally.
REQ-009 SHALL assert load_use when a source hits entry 0 with is_load = 1.
REQ-010 SHALL drive ctrl_o_regF_stall = ctrl_o_regD_stall = (load_use || sb_o_busy) && !execute_i_need_jump.
REQ-011 SHALL drive ctrl_o_regE_bubble = execute_i_need_jump || (load_use && !sb_o_busy).
REQ-012 SHALL drive ctrl_o_regD_bubble = execute_i_need_jump; jump has priority over load_use and stall.
REQ-013 SHALL drive sb_o_issue = dec_i_valid && !stall && !execute_i_need_jump && !load_use.
REQ-014 SHALL load a LAT_W counter with dec_i_mc_lat when issuing with mc_lat != 0, decrement while nonzero, saturate at 0; sb_o_busy = counter != 0.
REQ-015 SHALL drive ctrl_o_regE_stall = ctrl_o_regM_bubble = sb_o_busy.
REQ-016 SHALL ignore execute_i_need_jump while sb_o_busy = 1 (the E instruction has not resolved).
REQ-017 SHALL make every output a function of current state and inputs only (no input-to-state combinational loop).

Reset
REQ-018 SHALL on rst = 0 asynchronously clear all entries to invalid and the counter to 0.
REQ-019 SHALL in reset drive all stall/bubble/busy/issue outputs 0 and fwd selects 0.
REQ-020 SHALL, on reset asserted mid multi-cycle op, abort it; first post-reset edge behaves as empty pipeline.

Configuration
REQ-021 SHALL, with SCB_MC_EN defined, implement REQ-014/015/016 as above.
REQ-022 SHALL, without SCB_MC_EN, omit the counter, ignore dec_i_mc_lat, and tie sb_o_busy, ctrl_o_regE_stall, ctrl_o_regM_bubble to 0.

Verification
REQ-023 Bench SHALL check: issue rd=5 (ALU), next decode rs1=5 -> sb_o_fwd1_sel=1, no stall; one cycle later fwd1_sel=2.
REQ-024 Bench SHALL check: load rd=7, next decode rs2=7 -> one cycle regF/regD_stall=1, regE_bubble=1; next cycle fwd2_sel=2, issue=1.
REQ-025 Bench SHALL check: load rd=7 with execute_i_need_jump=1 same cycle -> regD_bubble=1, regE_bubble=1, stall=0, issue=0.
REQ-026 Bench SHALL check: rd=0 writer then rs1=0 reader -> fwd1_sel=0; entries rd=3 at 0 and 2, rs1=3 -> fwd1_sel=1.
REQ-027 Bench SHALL check (SCB_MC_EN): issue mc_lat=4 -> busy=1 for exactly 4 cycles with regE_stall=1, regM_bubble=1, F/D stalled, entries frozen; jump input ignored meanwhile.
REQ-028 Bench SHALL check: rst=0 asserted during busy -> outputs 0 immediately; after release, independent instruction issues first cycle.
